// File: rtl/logic_unit_arbiter.sv
// Two-port round-robin arbiter in front of one shared combinational 32-bit logic unit,
// with a single registered result slot returned over per-port valid/ready.
// Optional define LOGIC_UNIT_ARB_FIXED_PRIO_EN: port 0 always wins contention.
module logic_unit_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0]       req0_op,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [1:0]       lu_op,
  output logic [WIDTH-1:0] lu_a,
  output logic [WIDTH-1:0] lu_b,
  input  logic [WIDTH-1:0] lu_o
);

  typedef enum logic {EMPTY, FULL} state_t;

  typedef struct packed {
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } req_t;

  state_t           state, state_nxt;
  logic             owner, owner_nxt;
  logic             last_grant, last_grant_nxt;
  logic [WIDTH-1:0] slot, slot_nxt;
  logic             can_accept;
  logic [1:0]       grant;
  req_t [1:0]       req;
  req_t             sel;

  assign req[0] = {req0_op, req0_a, req0_b};
  assign req[1] = {req1_op, req1_a, req1_b};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      slot       <= '0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_grant <= last_grant_nxt;
      slot       <= slot_nxt;
    end
  end

  always_comb begin
    grant          = 2'b00;
    sel            = '0;
    state_nxt      = state;
    owner_nxt      = owner;
    last_grant_nxt = last_grant;
    slot_nxt       = slot;
    // A full slot can be refilled in the same cycle its owner drains it.
    can_accept     = (state == EMPTY) || rsp_ready[owner];

    if (can_accept) begin
      case (req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
`ifdef LOGIC_UNIT_ARB_FIXED_PRIO_EN
        2'b11:   grant = 2'b01;
`else
        2'b11:   grant = last_grant ? 2'b01 : 2'b10;
`endif
        default: grant = 2'b00;
      endcase
    end

    if (grant[1])      sel = req[1];
    else if (grant[0]) sel = req[0];

    if (|grant) begin
      state_nxt      = FULL;
      owner_nxt      = grant[1];
      last_grant_nxt = grant[1];
      slot_nxt       = lu_o;
    end else if (state == FULL && rsp_ready[owner]) begin
      state_nxt = EMPTY;
    end
  end

  assign req_ready = grant;
  assign lu_op     = sel.op;
  assign lu_a      = sel.a;
  assign lu_b      = sel.b;
  assign rsp_valid = (state == FULL) ? (owner ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_data  = slot;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter: stimulus pushes expected responses,
// a negedge monitor pops and compares on each response handshake.
module tb_logic_unit_arbiter;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst_n;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0]       req0_op, req1_op;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic [1:0]       lu_op;
  logic [WIDTH-1:0] lu_a, lu_b, lu_o;

  typedef struct {
    logic             port;
    logic [WIDTH-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   vectors;
  int   miscompares;

  logic_unit_arbiter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_op(req0_op), .req1_op(req1_op),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .lu_op(lu_op), .lu_a(lu_a), .lu_b(lu_b), .lu_o(lu_o)
  );

  // Shared logic unit the arbiter drives
  always_comb begin
    case (lu_op)
      2'b00:   lu_o = lu_a ^ lu_b;
      2'b01:   lu_o = lu_a & lu_b;
      2'b10:   lu_o = lu_a | lu_b;
      default: lu_o = ~(lu_a | lu_b);
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic port, input logic [WIDTH-1:0] data);
    exp_t e;
    e.port = port;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Monitor: compare every completed response handshake against the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int i = 0; i < 2; i++) begin
          if (rsp_valid[i] && rsp_ready[i]) begin
            if (exp_q.size() == 0) begin
              vectors++;
              miscompares++;
              $display("FAIL rsp_unexpected: port %0d data 0x%08h, expected no response", i, rsp_data);
            end else begin
              exp_t e;
              e = exp_q.pop_front();
              chk("rsp_port", 32'(i), 32'(e.port));
              chk("rsp_data", rsp_data, e.data);
            end
          end
        end
      end
    end
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n     = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    req0_op = 2'b00; req1_op = 2'b00;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    #2;
    chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset_rsp_data", rsp_data, 32'h0);
    chk("reset_req_ready", 32'(req_ready), 32'h0);
    chk("reset_lu_a", lu_a, 32'h0);
    step();
    step();
    rst_n = 1'b1;

    // Single request, XOR on port 0
    step();
    req_valid = 2'b01; rsp_ready = 2'b11;
    req0_op = 2'b00; req0_a = 32'hFFFF0000; req0_b = 32'h0F0F0F0F;
    #1;
    chk("single_req_ready", 32'(req_ready), 32'h1);
    chk("single_lu_a", lu_a, 32'hFFFF0000);
    chk("single_lu_op", 32'(lu_op), 32'h0);
    push(1'b0, 32'hF0F00F0F);
    step();
    req_valid = 2'b00;
    #1;
    chk("single_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("single_rsp_data", rsp_data, 32'hF0F00F0F);
    chk("single_idle_lu_b", lu_b, 32'h0);
    step();
    #1;
    chk("single_drained", 32'(rsp_valid), 32'h0);

    // Backpressure on port 1; port 0 rsp_ready must be ignored
    req_valid = 2'b10; rsp_ready = 2'b01;
    req1_op = 2'b01; req1_a = 32'h12345678; req1_b = 32'hFF00FF00;
    #1;
    chk("bp_req_ready", 32'(req_ready), 32'h2);
    push(1'b1, 32'h12005600);
    for (int k = 0; k < 3; k++) begin
      step();
      req_valid = 2'b01;
      req0_op = 2'b00; req0_a = 32'hFFFFFFFF; req0_b = 32'h00000001;
      #1;
      chk("bp_hold_ready", 32'(req_ready), 32'h0);
      chk("bp_hold_valid", 32'(rsp_valid), 32'h2);
      chk("bp_hold_data", rsp_data, 32'h12005600);
    end

    // Drain port 1 while accepting port 0, then drain port 0 while accepting port 1
    rsp_ready = 2'b11;
    #1;
    chk("refill0_req_ready", 32'(req_ready), 32'h1);
    push(1'b0, 32'hFFFFFFFE);
    step();
    req_valid = 2'b10;
    req1_op = 2'b10; req1_a = 32'h00000001; req1_b = 32'h00000002;
    #1;
    chk("refill1_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("refill1_req_ready", 32'(req_ready), 32'h2);
    push(1'b1, 32'h00000003);
    step();
    req_valid = 2'b00;
    #1;
    chk("refill1_switch_valid", 32'(rsp_valid), 32'h2);
    chk("refill1_data", rsp_data, 32'h00000003);

    // Reset mid-flight: the pending response is dropped
    step();
    rsp_ready = 2'b00; req_valid = 2'b01;
    req0_op = 2'b01; req0_a = 32'hFFFFFFFF; req0_b = 32'h0000FFFF;
    step();
    req_valid = 2'b00;
    #1;
    chk("midrst_full", 32'(rsp_valid), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("midrst_rsp_data", rsp_data, 32'h0);
    step();
    rst_n = 1'b1;
    step();
    #1;
    chk("postrst_no_rsp", 32'(rsp_valid), 32'h0);

    // Continuous contention, port 0 AND, port 1 NOR
    rsp_ready = 2'b11; req_valid = 2'b11;
    req0_op = 2'b01; req0_a = 32'hA5A5A5A5; req0_b = 32'hFFFF0000;
    req1_op = 2'b11; req1_a = 32'h0; req1_b = 32'h0;
    for (int k = 0; k < 4; k++) begin
      logic g;
`ifdef LOGIC_UNIT_ARB_FIXED_PRIO_EN
      g = 1'b0;
`else
      g = k[0];
`endif
      #1;
      chk("contend_grant", 32'(req_ready), g ? 32'h2 : 32'h1);
      push(g, g ? 32'hFFFFFFFF : 32'hA5A50000);
      step();
    end
    req_valid = 2'b10;
    #1;
    chk("contend_p1_alone", 32'(req_ready), 32'h2);
    push(1'b1, 32'hFFFFFFFF);
    step();
    req_valid = 2'b00;
    #1;
    chk("contend_last_rsp", 32'(rsp_valid), 32'h2);
    step();
    step();
    #1;
    chk("final_idle", 32'(rsp_valid), 32'h0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/logic_unit_arbiter.md
# logic_unit_arbiter

Two-port round-robin arbiter that shares one combinational 32-bit logic unit (XOR/AND/OR/NOR) between two requesters, e.g. the EX stage and the debug/self-test port. It accepts requests over valid/ready handshakes and drives the shared unit's operand and op inputs from the granted request. It captures the unit's result into a single output slot and returns it to the owning requester over a per-port valid/ready response channel. It sits beside the EX stage and owns the only instance of the logic unit.

## Interface
- WIDTH, 32, operand/result width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  2  bit i: requester i presents a request
- req_ready  out  2  bit i: request i accepted this cycle (one-hot or zero)
- req0_op, req1_op  in  2  op per requester: 00 XOR, 01 AND, 10 OR, 11 NOR
- req0_a, req0_b, req1_a, req1_b  in  WIDTH  operands per requester
- rsp_valid  out  2  bit i: rsp_data belongs to requester i (one-hot or zero)
- rsp_ready  in  2  bit i: requester i takes its response
- rsp_data  out  WIDTH  registered result
- lu_op  out  2  op to shared logic unit
- lu_a, lu_b  out  WIDTH  operands to shared logic unit
- lu_o  in  WIDTH  shared logic unit result (combinational from lu_*)

## Operation
- Slot FSM, two states: EMPTY, FULL(owner). Reset -> EMPTY.
- can_accept = EMPTY, or FULL with rsp_ready[owner]=1 (drain and refill in the same cycle).
- Grant: if can_accept and exactly one req_valid bit set -> grant it. If both set -> grant the port other than last_grant. last_grant resets to 1, so port 0 wins the first contention.
- req_ready = grant (combinational). The accept of port i occurs when req_valid[i] & req_ready[i].
- lu_op/lu_a/lu_b = granted request's fields. With no grant, drive all zero.
- On accept: slot <= lu_o, owner <= i, last_grant <= i, state FULL.
- FULL with rsp_ready[owner]=1 and no new accept -> EMPTY.
- FULL with rsp_ready[owner]=0 -> hold slot, owner and rsp_data stable; req_ready=0.
- rsp_ready of the non-owner port is ignored.
- req_ready never depends on the requester's own req_valid beyond the grant choice. Requesters must hold req_valid and fields stable until accepted.

## Timing
- Reset (async assert, sync-safe deassert by upstream): rsp_valid=00, rsp_data=0, req_ready=00, lu_*=0, state EMPTY, last_grant=1.
- Latency: request accepted in cycle N -> rsp_valid[i]=1 with result in cycle N+1.
- Throughput: one result per cycle while the owner holds rsp_ready=1. Under continuous contention, grants alternate 0,1,0,1.
- Simultaneous drain plus new accept: old response completes at the edge and the new result replaces it. rsp_valid switches owner with no bubble.
- rst_n asserted mid-transaction: the pending response is discarded; no rsp_valid after release until a new accept.
- Combinational path: req fields -> lu_* -> lu_o -> slot register within one cycle.

## Configuration
- LOGIC_UNIT_ARB_FIXED_PRIO_EN defined: port 0 always wins contention; last_grant is not used for arbitration (it may still be kept).
- Not defined: round-robin as above (default).

## Test plan
- Single request: port 0 op=00, a=0xFFFF0000, b=0x0F0F0F0F, rsp_ready=1 -> req_ready=01 same cycle; next cycle rsp_valid=01, rsp_data=0xF0F00F0F, then 00.
- Contention: both valid continuously, rsp_ready=11, port 1 NOR a=0,b=0 -> grants 0,1,0,1. Port 1 responses are 0xFFFFFFFF, each one cycle after its grant.
- Backpressure: port 1 AND a=0x12345678, b=0xFF00FF00, rsp_ready[1]=0 for 3 cycles -> rsp_data=0x12005600 held; req_ready=00 for those cycles; port 0 rsp_ready ignored.
- Drain-and-refill: FULL(owner 0) with rsp_ready[0]=1 while port 1 requests OR 0x1/0x2 -> same-cycle accept; next cycle rsp_valid=10, rsp_data=0x00000003.
- Reset mid-flight: assert rst_n=0 while FULL -> rsp_valid=00 and rsp_data=0 immediately (async); after release, first contention grants port 0.
- With LOGIC_UNIT_ARB_FIXED_PRIO_EN: both valid for 4 accepts -> all granted to port 0; port 1 accepted only after req_valid[0] drops.
